echo_fifo_n: RTL and testbench

Parametrised echo server: accepts tagged requests, buffers them in a DEPTH-entry FIFO, and returns each payload on the indication port in order, optionally transformed. It supports a per-request transform mode, channel tags, and indication-side backpressure. It sits between the request dispatcher and the indication proxy, and replaces the fixed 32-bit, single-entry echo block in new designs.

---
 rtl/echo_fifo_n.sv | 120 ++++++++++++
 tb/tb_echo_fifo_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_fifo_n.sv
`default_nettype none
// ============================================================================
// Module      : echo_fifo_n
// Description : Parametrised echo server. Tagged requests are transformed at
//               enqueue and held in a DEPTH-entry first-word-fall-through
//               FIFO. Responses are returned in strict order on the
//               indication port, which supports backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_fifo_n #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CHW   = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     echoReq__ENA,
  input  logic [WIDTH-1:0]         echoReq_v,
  input  logic [CHW-1:0]           echoReq_ch,
  input  logic [1:0]               echoReq_mode,
  output logic                     echoReq__RDY,
  output logic                     ind_echo__ENA,
  output logic [WIDTH-1:0]         ind_echo_v,
  output logic [CHW-1:0]           ind_echo_ch,
  input  logic                     ind_echo__RDY,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [31:0]              echo_count
);

  localparam int              c_AW       = $clog2(DEPTH);
  localparam int              c_HALF     = WIDTH / 2;
  localparam int              c_EW       = CHW + WIDTH;
  localparam logic [c_AW:0]   c_FULL     = (c_AW+1)'(DEPTH);
  localparam logic [c_AW:0]   c_OCC_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
  localparam logic [1:0]      c_MODE_PASS = 2'd0;
  localparam logic [1:0]      c_MODE_INC  = 2'd1;
  localparam logic [1:0]      c_MODE_INV  = 2'd2;

  logic [c_EW-1:0]  r_mem [DEPTH];
  logic [c_AW-1:0]  r_wptr;
  logic [c_AW-1:0]  r_rptr;
  logic [c_AW:0]    r_occ;
  logic [31:0]      r_count;

  logic [WIDTH-1:0] w_swap;
  logic [WIDTH-1:0] w_xform;
  logic [c_EW-1:0]  w_head;
  logic             w_enq;
  logic             w_deq;

  // Half swap: upper and lower halves trade places; an odd middle bit stays put.
  for (genvar i = 0; i < WIDTH; i++) begin : g_swap
    if (i < c_HALF) begin : g_lo
      assign w_swap[i] = echoReq_v[i + WIDTH - c_HALF];
    end else if (i >= WIDTH - c_HALF) begin : g_hi
      assign w_swap[i] = echoReq_v[i - (WIDTH - c_HALF)];
    end else begin : g_mid
      assign w_swap[i] = echoReq_v[i];
    end
  end

  // Select the payload transform applied on the way into the FIFO.
  always_comb begin
    w_xform = echoReq_v;
    case (echoReq_mode)
      c_MODE_PASS: w_xform = echoReq_v;
      c_MODE_INC:  w_xform = echoReq_v + WIDTH'(1);
      c_MODE_INV:  w_xform = ~echoReq_v;
      default:     w_xform = w_swap;
    endcase
  end

  // Handshake flags come from registered occupancy only, so there is no
  // combinational path from either strobe to the opposite ready/valid.
  assign echoReq__RDY  = nRST && (r_occ != c_FULL);
  assign ind_echo__ENA = nRST && (r_occ != '0);
  assign w_enq         = echoReq__ENA && echoReq__RDY;
  assign w_deq         = ind_echo__ENA && ind_echo__RDY;

  // Head entry is presented whenever valid; zero otherwise (including reset).
  assign w_head      = r_mem[r_rptr];
  assign ind_echo_v  = ind_echo__ENA ? w_head[WIDTH-1:0]    : '0;
  assign ind_echo_ch = ind_echo__ENA ? w_head[c_EW-1:WIDTH] : '0;
  assign occupancy   = r_occ;
  assign echo_count  = r_count;

  // Storage write: the slot at the write pointer is never the live head
  // unless the FIFO is empty, so a stalled head cannot be disturbed.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_mem[r_wptr] <= {echoReq_ch, w_xform};
    end
  end

  // Pointers, occupancy and delivered-response counter.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_occ   <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + c_PTR_ONE;
      end
      if (w_deq) begin
        r_rptr  <= r_rptr + c_PTR_ONE;
        r_count <= r_count + 32'd1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_occ <= r_occ + c_OCC_ONE;
        2'b01:   r_occ <= r_occ - c_OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_echo_fifo_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_fifo_n
// Description : Self-checking bench for echo_fifo_n (WIDTH=32, DEPTH=4,
//               CHW=2): directed vector table, corner-case sequences and
//               randomized traffic against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_fifo_n;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CHW   = 2;

  logic             CLK;
  logic             nRST;
  logic             echoReq__ENA;
  logic [WIDTH-1:0] echoReq_v;
  logic [CHW-1:0]   echoReq_ch;
  logic [1:0]       echoReq_mode;
  logic             echoReq__RDY;
  logic             ind_echo__ENA;
  logic [WIDTH-1:0] ind_echo_v;
  logic [CHW-1:0]   ind_echo_ch;
  logic             ind_echo__RDY;
  logic [2:0]       occupancy;
  logic [31:0]      echo_count;

  echo_fifo_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHW(CHW)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .echoReq__ENA  (echoReq__ENA),
    .echoReq_v     (echoReq_v),
    .echoReq_ch    (echoReq_ch),
    .echoReq_mode  (echoReq_mode),
    .echoReq__RDY  (echoReq__RDY),
    .ind_echo__ENA (ind_echo__ENA),
    .ind_echo_v    (ind_echo_v),
    .ind_echo_ch   (ind_echo_ch),
    .ind_echo__RDY (ind_echo__RDY),
    .occupancy     (occupancy),
    .echo_count    (echo_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] v;
    logic [1:0]  ch;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_count;

  // Reference transform written straight from the mode definitions.
  function automatic logic [31:0] xf(input logic [1:0] mode, input logic [31:0] v);
    case (mode)
      2'd0:    return v;
      2'd1:    return v + 32'd1;
      2'd2:    return ~v;
      default: return (v << 16) | (v >> 16);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, compare against the model, then
  // let the rising edge happen and advance the model by the same rules.
  task automatic step(input logic ena, input logic [31:0] v, input logic [1:0] ch,
                      input logic [1:0] mode, input logic rdy, input logic rst_n);
    logic e_rdy, e_ena, fe, fd;
    ent_t e;
    echoReq__ENA  = ena;
    echoReq_v     = v;
    echoReq_ch    = ch;
    echoReq_mode  = mode;
    ind_echo__RDY = rdy;
    nRST          = rst_n;
    #1;
    e_rdy = rst_n && (q.size() < DEPTH);
    e_ena = rst_n && (q.size() > 0);
    chk("req_rdy", {31'd0, echoReq__RDY}, {31'd0, e_rdy});
    chk("ind_ena", {31'd0, ind_echo__ENA}, {31'd0, e_ena});
    if (e_ena) begin
      chk("ind_v", ind_echo_v, q[0].v);
      chk("ind_ch", {30'd0, ind_echo_ch}, {30'd0, q[0].ch});
    end
    if (!rst_n) begin
      chk("rst_v", ind_echo_v, 32'd0);
      chk("rst_ch", {30'd0, ind_echo_ch}, 32'd0);
    end
    chk("occupancy", {29'd0, occupancy}, q.size());
    chk("echo_count", echo_count, m_count);
    @(posedge CLK);
    if (!rst_n) begin
      q.delete();
      m_count = 32'd0;
    end else begin
      fd = (q.size() > 0) && rdy;
      fe = ena && (q.size() < DEPTH);
      if (fd) begin
        void'(q.pop_front());
        m_count = m_count + 32'd1;
      end
      if (fe) begin
        e.v  = xf(mode, v);
        e.ch = ch;
        q.push_back(e);
      end
    end
    @(negedge CLK);
  endtask

  typedef struct {
    logic        ena;
    logic [31:0] v;
    logic [1:0]  ch;
    logic [1:0]  mode;
    logic        rdy;
    logic        x_ena;
    logic [31:0] x_v;
    logic [1:0]  x_ch;
    logic [2:0]  x_occ;
    logic [31:0] x_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] head;
    int got;

    // Inputs apply for the row's cycle; expectations are the outputs seen
    // in that same cycle, before the rising edge.
    tbl[0] = '{1'b0, 32'h0,        2'd0, 2'd0, 1'b1, 1'b0, 32'h0,        2'd0, 3'd0, 32'd0};
    tbl[1] = '{1'b1, 32'h12345678, 2'd1, 2'd0, 1'b1, 1'b0, 32'h0,        2'd0, 3'd0, 32'd0};
    tbl[2] = '{1'b0, 32'h0,        2'd0, 2'd0, 1'b1, 1'b1, 32'h12345678, 2'd1, 3'd1, 32'd0};
    tbl[3] = '{1'b0, 32'h0,        2'd0, 2'd0, 1'b1, 1'b0, 32'h0,        2'd0, 3'd0, 32'd1};
    tbl[4] = '{1'b1, 32'hFFFFFFFF, 2'd2, 2'd1, 1'b1, 1'b0, 32'h0,        2'd0, 3'd0, 32'd1};
    tbl[5] = '{1'b1, 32'h0000FFFF, 2'd3, 2'd2, 1'b1, 1'b1, 32'h00000000, 2'd2, 3'd1, 32'd1};
    tbl[6] = '{1'b1, 32'h1234ABCD, 2'd0, 2'd3, 1'b1, 1'b1, 32'hFFFF0000, 2'd3, 3'd1, 32'd2};
    tbl[7] = '{1'b0, 32'h0,        2'd0, 2'd0, 1'b1, 1'b1, 32'hABCD1234, 2'd0, 3'd1, 32'd3};
    tbl[8] = '{1'b0, 32'h0,        2'd0, 2'd0, 1'b1, 1'b0, 32'h0,        2'd0, 3'd0, 32'd4};

    m_count       = 32'd0;
    nRST          = 1'b0;
    echoReq__ENA  = 1'b0;
    echoReq_v     = '0;
    echoReq_ch    = '0;
    echoReq_mode  = '0;
    ind_echo__RDY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    // Reset still asserted: registers cleared, outputs forced low.
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      echoReq__ENA  = tbl[i].ena;
      echoReq_v     = tbl[i].v;
      echoReq_ch    = tbl[i].ch;
      echoReq_mode  = tbl[i].mode;
      ind_echo__RDY = tbl[i].rdy;
      nRST          = 1'b1;
      #1;
      chk($sformatf("tbl%0d_rdy", i), {31'd0, echoReq__RDY}, 32'd1);
      chk($sformatf("tbl%0d_ena", i), {31'd0, ind_echo__ENA}, {31'd0, tbl[i].x_ena});
      if (tbl[i].x_ena) begin
        chk($sformatf("tbl%0d_v", i), ind_echo_v, tbl[i].x_v);
        chk($sformatf("tbl%0d_ch", i), {30'd0, ind_echo_ch}, {30'd0, tbl[i].x_ch});
      end
      chk($sformatf("tbl%0d_occ", i), {29'd0, occupancy}, {29'd0, tbl[i].x_occ});
      chk($sformatf("tbl%0d_cnt", i), echo_count, tbl[i].x_cnt);
      step(tbl[i].ena, tbl[i].v, tbl[i].ch, tbl[i].mode, tbl[i].rdy, 1'b1);
    end

    // Backpressure: 5 requests into a stalled FIFO, 5th dropped.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hA0000000 + 32'(i), 2'(i), 2'd0, 1'b0, 1'b1);
      if (i == 0) head = ind_echo_v;
    end
    chk("full_occ", {29'd0, occupancy}, 32'd4);
    chk("full_rdy", {31'd0, echoReq__RDY}, 32'd0);
    chk("full_head", ind_echo_v, 32'hA0000000);
    chk("stall_head", head, 32'hA0000000);
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1);
    chk("rdy_after_deq", {31'd0, echoReq__RDY}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1);
    chk("drained_ena", {31'd0, ind_echo__ENA}, 32'd0);
    chk("drained_cnt", echo_count, 32'd8);

    // Streaming: 20 back-to-back requests, occupancy settles at 1.
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (ind_echo__ENA) got++;
      if (i > 0) chk("stream_occ", {29'd0, occupancy}, 32'd1);
      step(1'b1, $urandom, 2'($urandom), 2'($urandom), 1'b1, 1'b1);
    end
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1);
    got++;
    chk("stream_responses", 32'(got), 32'd20);
    chk("stream_cnt", echo_count, 32'd28);

    // Reset with 3 buffered entries discards them.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC0DE0000 + 32'(i), 2'd1, 2'd0, 1'b0, 1'b1);
    chk("pre_rst_occ", {29'd0, occupancy}, 32'd3);
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b0);
    chk("post_rst_occ", {29'd0, occupancy}, 32'd0);
    chk("post_rst_ena", {31'd0, ind_echo__ENA}, 32'd0);
    step(1'b1, 32'h00000041, 2'd3, 2'd1, 1'b1, 1'b1);
    chk("post_rst_v", ind_echo_v, 32'h00000042);
    step(1'b0, 32'h0, 2'd0, 2'd0, 1'b1, 1'b1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, 2'($urandom), 2'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
